// File: rtl/pp_sum_216.sv
// pp_sum_216: final reduction of the five group sums into one product.
// A single Radix-bit adder is reused over the low and high halves of each
// operand, with the low-half carry held in a register between the two steps.
module pp_sum_216 #(
  parameter int unsigned Radix = 108
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*Radix-1:0]   res_0,
  input  logic [2*Radix-1:0]   res_1,
  input  logic [2*Radix-1:0]   res_2,
  input  logic [2*Radix-1:0]   res_3,
  input  logic [2*Radix-1:0]   res_4,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*Radix-1:0]   prod,
  output logic                 busy
);

  localparam int unsigned Width = 2 * Radix;
  localparam int unsigned NumOps = 5;

  typedef enum logic [1:0] {
    StIdle,
    StAcc,
    StDone
  } state_e;

  state_e             r_state;
  state_e             w_state_next;

  logic [Width-1:0]   r_op [NumOps];
  logic [Width-1:0]   r_acc;
  logic [Width-1:0]   r_prod;
  logic               r_carry;
  logic               r_half;
  logic [2:0]         r_idx;

  logic               w_capture;
  logic               w_last;
  logic [Width-1:0]   w_op;
  logic [Radix-1:0]   w_add_a;
  logic [Radix-1:0]   w_add_b;
  logic               w_add_cin;
  logic [Radix:0]     w_sum;

  // Handshake and status outputs are pure decodes of the state register.
  assign in_ready  = (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign busy      = (r_state != StIdle);
  assign prod      = r_prod;

  assign w_capture = in_valid && in_ready;
  // High-half step of the fifth operand: the accumulator is complete after it.
  assign w_last    = (r_state == StAcc) && (r_idx == 3'd4) && r_half;

  // Select the operand being accumulated this pair of cycles.
  always_comb begin
    w_op = r_op[0];
    case (r_idx)
      3'd1:    w_op = r_op[1];
      3'd2:    w_op = r_op[2];
      3'd3:    w_op = r_op[3];
      3'd4:    w_op = r_op[4];
      default: w_op = r_op[0];
    endcase
  end

  // Shared adder: low halves with no carry-in, high halves with the saved carry.
  always_comb begin
    w_add_a   = r_half ? r_acc[Width-1:Radix] : r_acc[Radix-1:0];
    w_add_b   = r_half ? w_op[Width-1:Radix]  : w_op[Radix-1:0];
    w_add_cin = r_half & r_carry;
    w_sum     = {1'b0, w_add_a} + {1'b0, w_add_b} + {{Radix{1'b0}}, w_add_cin};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode: IDLE -> ACC on capture, ACC -> DONE after the last step,
  // DONE -> IDLE once the consumer takes the product.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (in_valid) begin
          w_state_next = StAcc;
        end
      end
      StAcc: begin
        if ((r_idx == 3'd4) && r_half) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Operand capture; upstream may change res_* freely once this has happened.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumOps; i++) begin
        r_op[i] <= '0;
      end
    end else if (w_capture) begin
      r_op[0] <= res_0;
      r_op[1] <= res_1;
      r_op[2] <= res_2;
      r_op[3] <= res_3;
      r_op[4] <= res_4;
    end
  end

  // Accumulator, carry and step counters; one adder operation per ACC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_half  <= 1'b0;
      r_idx   <= 3'd0;
    end else if (w_capture) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_half  <= 1'b0;
      r_idx   <= 3'd0;
    end else if (r_state == StAcc) begin
      if (!r_half) begin
        r_acc[Radix-1:0] <= w_sum[Radix-1:0];
        r_carry          <= w_sum[Radix];
        r_half           <= 1'b1;
      end else begin
        // Carry out of the top half is dropped: the result is modulo 2^Width.
        r_acc[Width-1:Radix] <= w_sum[Radix-1:0];
        r_carry              <= 1'b0;
        r_half               <= 1'b0;
        r_idx                <= r_idx + 3'd1;
      end
    end
  end

  // Product register, loaded with the completed sum and held through DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod <= '0;
    end else if (w_last) begin
      r_prod <= {w_sum[Radix-1:0], r_acc[Radix-1:0]};
    end
  end

  // A stalled product must not move, and the block never offers both sides.
  a_prod_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(prod)));

  a_ready_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(in_ready && out_valid));

endmodule

// File: doc/pp_sum_216.md
Name: pp_sum_216

Overview:
- Downstream stage of the 24-partial-product compressor in the 108-radix multiplier path.
- Consumes the five 216-bit group sums res_0..res_4 and reduces them to one final 216-bit product.
- Uses a single radix-bit adder, time-multiplexed over low/high halves with a registered carry, so the critical path is one 108-bit add.
- Valid/ready handshake on both input and output sides.

Parameters:
radix, 108, chunk width; the datapath is radix*2 bits, split into two radix-bit halves.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  res_0..res_4 are valid
in_ready  output  1  block can accept an operand set
res_0  input  radix*2  group sum 0
res_1  input  radix*2  group sum 1
res_2  input  radix*2  group sum 2
res_3  input  radix*2  group sum 3
res_4  input  radix*2  group sum 4
out_valid  output  1  prod is valid
out_ready  input  1  consumer accepts prod
prod  output  radix*2  (res_0+res_1+res_2+res_3+res_4) mod 2^(radix*2)
busy  output  1  high in ACC or DONE

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, busy=0, prod=0.
  - Operand registers, accumulator, carry, idx and half all 0.
- States: IDLE, ACC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge: capture res_0..res_4 into operand registers, clear acc and carry, set idx=0, half=0, go to ACC.
- ACC (in_ready=0), one adder operation per cycle:
  - half=0: {carry, acc[radix-1:0]} <= acc[radix-1:0] + op[idx][radix-1:0]; half<=1.
  - half=1: acc[2radix-1:radix] <= acc[2radix-1:radix] + op[idx][2radix-1:radix] + carry; carry out of the MSB is discarded (modulo 2^(2radix)); carry<=0; half<=0; idx<=idx+1.
  - The step with idx=4 and half=1 moves to DONE and loads prod with the final acc value.
  - ACC lasts exactly 10 cycles.
- DONE:
  - out_valid=1; prod is held stable until out_valid&&out_ready.
  - On that handshake edge: out_valid<=0, go to IDLE; in_ready is 1 in the following cycle.
- Latency and throughput:
  - Capture edge at cycle N gives out_valid high from cycle N+10.
  - If out_ready is held high, a new set can be accepted at cycle N+12. Minimum spacing is 12 cycles.
- in_valid outside IDLE is ignored; no capture and no error flag. Upstream holds its data until in_ready.
- Operands are registered at capture, so res_* may change freely after the handshake.
- out_ready while out_valid=0 has no effect.
- busy = (state != IDLE).
- rst_n low mid-ACC or in DONE: immediate return to reset values. The partial result is discarded and out_valid drops asynchronously.
- Arithmetic: unsigned; result truncated to radix*2 bits. This matches upstream truncation of each group sum.

Test Plan:
- Zero operands: all res_*=0 -> out_valid 10 cycles after capture, prod=0.
- Small values: res_0..res_4 = 1,2,3,4,5 -> prod=15.
- Carry across the chunk boundary: res_0=2^108-1, res_1=1, others 0 -> prod=2^108; also all five =2^108-1 -> prod=5*(2^108-1).
- Wrap-around: all five =2^216-1 -> prod = 2^216-5 (mod 2^216), i.e. 216'hFF..FB.
- Backpressure and ignore-while-busy:
  - out_ready=0 for 20 cycles after out_valid -> prod and out_valid held; in_ready stays 0.
  - in_valid pulsed with different data during ACC and DONE -> the result is unchanged.
  - Releasing out_ready -> in_ready=1 next cycle, and a second set is accepted and summed correctly.
- Reset mid-ACC: assert rst_n low at the 5th ACC cycle -> out_valid=0, in_ready=1 after release; a following set 7,8,9,10,11 yields prod=45 with no residue from the aborted set.
